arr_conv_sequencer: RTL
=======================

// Module: arr_conv_sequencer
// PURPOSE
//  Parametrised array controller: holds the layer config register file and sequences input-buffer
//  read addresses for the systolic array. Generalises kernel size, stride, channel count and mode.
//  Sits between host config bus and input SRAM; one address per valid/ready beat to the array feeder.
// PARAMETERS
//  ROWS    16  array rows (reported on status only)
//  COLS    16  array cols (reported on status only)
//  CFG_DW   8  config register width; W,H,C,K each CFG_DW bits
//  NCFG     8  number of config registers (index width $clog2(NCFG))
//  ADDR_W  16  output address width
//  MAX_K    7  largest legal kernel size
// PORTS
//  clk        in   1        clock, all logic rising-edge
//  rst        in   1        synchronous reset, active-high
//  cfg_we     in   1        config write strobe
//  cfg_idx    in   clog2(NCFG) register index: 0 op, 1 C, 2 W, 3 H, 4 K, 5 S; others storage only
//  cfg_din    in   CFG_DW   config write data
//  start      in   1        begin sequence (sampled only in IDLE)
//  abort      in   1        terminate sequence
//  addr_valid out  1        addr/tags valid
//  addr_ready in   1        consumer accepts beat
//  addr       out  ADDR_W   input-buffer address
//  win_first  out  1        beat is first of a window (conv) / of stream (pass)
//  win_last   out  1        beat is last of a window
//  seq_last   out  1        final beat of the sequence
//  busy       out  1        high in SETUP/RUN
//  done       out  1        one-cycle pulse at completion
//  err        out  1        valid with done; 1 = illegal config, no beats issued
//  out_w      out  CFG_DW   OW latched in SETUP
//  out_h      out  CFG_DW   OH latched in SETUP
// BEHAVIOUR
//  Reset: all outputs 0, config regs 0, state IDLE. Reset mid-run behaves as abort plus config clear.
//  Config writes accepted only in IDLE; ignored when busy=1. Stride S in {1,2}.
//  FSM: IDLE -start-> SETUP (1 cycle) -> RUN, or -> DONE with err=1 if illegal;
//   RUN -last beat handshaked-> DONE; DONE (1 cycle, done=1) -> IDLE. abort in SETUP/RUN -> IDLE next
//   cycle; addr_valid drops, no done. start while busy ignored.
//  Illegal: C==0, W==0, H==0, K==0, K>MAX_K, K>W, K>H, S not in {1,2}, op>1 -> err.
//  SETUP: OW=((W-K)>>(S-1))+1, OH=((H-K)>>(S-1))+1; latched to out_w/out_h.
//  op 0 (conv): loop order oy, ox, c, ky, kx (kx innermost);
//   addr = c*W*H + (oy*S+ky)*W + (ox*S+kx), truncated to ADDR_W. Total beats OW*OH*C*K*K.
//   win_first at c=0,ky=0,kx=0; win_last at c=C-1,ky=K-1,kx=K-1.
//  op 1 (pass): addr 0..C*W*H-1 linear; win_first on beat 0, win_last=seq_last on final beat.
//  First addr_valid in cycle after SETUP (start->first valid = 2 cycles).
//  Handshake: beat transfers when addr_valid&addr_ready; addr/tags stable while valid&!ready;
//   valid never retracted except by abort/rst. Full throughput: one beat per cycle when ready=1.
//  done asserts cycle after the seq_last handshake; busy low in DONE.
//  Addresses maintained incrementally (base-register adds); no runtime multipliers in RUN path.
// STRUCTURE
//  arr_ctrl_pkg: config index constants, op codes, state enum, legality check function.
//  Sub-module arr_cfg_regfile: NCFG x CFG_DW registers, write gating by busy, reset clear.
//  Top: FSM, SETUP dims, nested loop counters, address/tag output register.
// TESTING
//  W=5,H=5,C=1,K=3,S=1,op0, ready=1 -> 81 beats; first 0,1,2,5,6,7,10,11,12 (win_last); last 24 seq_last; done next cycle.
//  Same, S=2 -> out_w=out_h=2, 36 beats; window 2 starts addr 2, window 3 starts addr 10, last 24.
//  C=2 same dims, S=1 -> window 0 beat 9 addr 25; 162 beats; win_last only at channel-1 end.
//  ready low 3 cycles mid-run -> addr/tags held constant, no beat skipped or duplicated.
//  W=3,K=4 start -> no addr_valid, done=1 err=1 two cycles after start; cfg write during RUN ignored.
//  abort at beat 20 -> addr_valid 0 next cycle, no done; restart reissues from addr 0; op1 C=1,W=2,H=2 -> 0..3.

Source files
------------

// File: rtl/arr_ctrl_pkg.sv
// Shared definitions for the conv array address sequencer:
// config register map, op codes, FSM states and config legality check.
package arr_ctrl_pkg;

  localparam int IDX_OP = 0;
  localparam int IDX_C  = 1;
  localparam int IDX_W  = 2;
  localparam int IDX_H  = 3;
  localparam int IDX_K  = 4;
  localparam int IDX_S  = 5;

  localparam int OP_CONV = 0;
  localparam int OP_PASS = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic cfg_legal(
    input int unsigned op,
    input int unsigned c,
    input int unsigned w,
    input int unsigned h,
    input int unsigned k,
    input int unsigned s,
    input int unsigned max_k
  );
    return (op <= OP_PASS) && (c != 0) &&
           (w != 0) && (h != 0) && (k != 0) &&
           (k <= max_k) && (k <= w) && (k <= h) &&
           ((s == 1) || (s == 2));
  endfunction

endpackage

// File: rtl/arr_cfg_regfile.sv
// Layer config register file: NCFG x CFG_DW, cleared on reset.
// Ports: clk, rst, lock (blocks writes), we/idx/din write port, regs out.
module arr_cfg_regfile #(
  parameter int NCFG   = 8,
  parameter int CFG_DW = 8,
  parameter int IW     = $clog2(NCFG)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lock,
  input  logic                         we,
  input  logic [IW-1:0]                idx,
  input  logic [CFG_DW-1:0]            din,
  output logic [NCFG-1:0][CFG_DW-1:0]  regs
);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we && !lock) begin
      regs[idx] <= din;
    end
  end

endmodule

// File: rtl/arr_conv_sequencer.sv
// Config regfile + address sequencer feeding the systolic array.
// Ports: host cfg write, start/abort, addr valid/ready stream, status.
module arr_conv_sequencer
  import arr_ctrl_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int CFG_DW = 8,
  parameter int NCFG   = 8,
  parameter int ADDR_W = 16,
  parameter int MAX_K  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(NCFG)-1:0] cfg_idx,
  input  logic [CFG_DW-1:0]       cfg_din,
  input  logic                    start,
  input  logic                    abort,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [ADDR_W-1:0]       addr,
  output logic                    win_first,
  output logic                    win_last,
  output logic                    seq_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [CFG_DW-1:0]       out_w,
  output logic [CFG_DW-1:0]       out_h
);

  localparam int PW = 3 * CFG_DW;
  localparam logic [CFG_DW-1:0] ONE = CFG_DW'(1);

  state_t state_q, state_d;

  logic [NCFG-1:0][CFG_DW-1:0] cfg;

  arr_cfg_regfile #(
    .NCFG   (NCFG),
    .CFG_DW (CFG_DW)
  ) u_regs (
    .clk  (clk),
    .rst  (rst),
    .lock (state_q != ST_IDLE),
    .we   (cfg_we),
    .idx  (cfg_idx),
    .din  (cfg_din),
    .regs (cfg)
  );

  logic [CFG_DW-1:0] op, c, w, h, k, s;
  assign op = cfg[IDX_OP];
  assign c  = cfg[IDX_C];
  assign w  = cfg[IDX_W];
  assign h  = cfg[IDX_H];
  assign k  = cfg[IDX_K];
  assign s  = cfg[IDX_S];

  logic legal, pass;
  assign legal = cfg_legal(32'(op), 32'(c), 32'(w),
                           32'(h), 32'(k), 32'(s),
                           32'(MAX_K));
  assign pass = op[0];

  logic [CFG_DW-1:0] span, ow_c, oh_c;
  assign span = (s == CFG_DW'(2)) ? ONE : '0;
  assign ow_c = ((w - k) >> span) + ONE;
  assign oh_c = ((h - k) >> span) + ONE;

  logic [CFG_DW-1:0] kx, ky, cc, ox, oy;
  logic [CFG_DW-1:0] ow_q, oh_q;
  // Window row, window origin, channel origin, kernel row origin.
  logic [ADDR_W-1:0] w_row, w_org, c_org, r_org, addr_q;
  logic [ADDR_W-1:0] plane, rstep, cstep;
  logic [PW-1:0]     pass_cnt, pass_end;
  logic              err_q;

  logic kx_l, ky_l, cc_l, ox_l, oy_l;
  logic win_l, seq_l, fire;
  assign kx_l  = kx == k - ONE;
  assign ky_l  = ky == k - ONE;
  assign cc_l  = cc == c - ONE;
  assign ox_l  = ox == ow_q - ONE;
  assign oy_l  = oy == oh_q - ONE;
  assign win_l = pass ? (pass_cnt == pass_end)
                      : (cc_l && ky_l && kx_l);
  assign seq_l = pass ? win_l : (win_l && ox_l && oy_l);

  assign addr_valid = state_q == ST_RUN;
  assign fire       = addr_valid && addr_ready;
  assign addr       = addr_q;
  assign win_first  = addr_valid &&
                      (pass ? (pass_cnt == '0)
                            : (cc == '0 && ky == '0 && kx == '0));
  assign win_last   = addr_valid && win_l;
  assign seq_last   = addr_valid && seq_l;
  assign busy       = state_q == ST_SETUP || state_q == ST_RUN;
  assign done       = state_q == ST_DONE;
  assign err        = done && err_q;
  assign out_w      = ow_q;
  assign out_h      = oh_q;

  assign cstep = ADDR_W'(s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: begin
        if (abort)      state_d = ST_IDLE;
        else if (legal) state_d = ST_RUN;
        else            state_d = ST_DONE;
      end
      ST_RUN: begin
        if (abort)              state_d = ST_IDLE;
        else if (fire && seq_l) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {kx, ky, cc, ox, oy} <= '0;
      {w_row, w_org, c_org, r_org, addr_q} <= '0;
      {plane, rstep} <= '0;
      {pass_cnt, pass_end} <= '0;
      ow_q  <= '0;
      oh_q  <= '0;
      err_q <= 1'b0;
    end else if (state_q == ST_SETUP) begin
      {kx, ky, cc, ox, oy} <= '0;
      {w_row, w_org, c_org, r_org, addr_q} <= '0;
      pass_cnt <= '0;
      // Products are only formed here, once per layer.
      pass_end <= PW'(c) * PW'(w) * PW'(h) - PW'(1);
      plane    <= ADDR_W'(w) * ADDR_W'(h);
      rstep    <= (s == CFG_DW'(2)) ? ADDR_W'(w) << 1
                                    : ADDR_W'(w);
      err_q    <= !legal;
      ow_q     <= legal ? ow_c : '0;
      oh_q     <= legal ? oh_c : '0;
    end else if (fire) begin
      if (pass) begin
        pass_cnt <= pass_cnt + PW'(1);
        addr_q   <= addr_q + ADDR_W'(1);
      end else if (!kx_l) begin
        kx     <= kx + ONE;
        addr_q <= addr_q + ADDR_W'(1);
      end else if (!ky_l) begin
        kx     <= '0;
        ky     <= ky + ONE;
        r_org  <= r_org + ADDR_W'(w);
        addr_q <= r_org + ADDR_W'(w);
      end else if (!cc_l) begin
        {kx, ky} <= '0;
        cc     <= cc + ONE;
        c_org  <= c_org + plane;
        r_org  <= c_org + plane;
        addr_q <= c_org + plane;
      end else if (!ox_l) begin
        {kx, ky, cc} <= '0;
        ox     <= ox + ONE;
        w_org  <= w_org + cstep;
        c_org  <= w_org + cstep;
        r_org  <= w_org + cstep;
        addr_q <= w_org + cstep;
      end else if (!oy_l) begin
        {kx, ky, cc, ox} <= '0;
        oy     <= oy + ONE;
        w_row  <= w_row + rstep;
        w_org  <= w_row + rstep;
        c_org  <= w_row + rstep;
        r_org  <= w_row + rstep;
        addr_q <= w_row + rstep;
      end
    end
  end

endmodule
